// File: rtl/scan_sequencer.sv
// Row/column scan sequencer: one address beat per step over a ROWS x COLS buffer
// with a configurable stride, plus lock-step enables for external counters.
module scan_sequencer #(
  parameter int unsigned ROWS       = 3,
  parameter int unsigned COLS       = 4,
  parameter int unsigned STRIDE     = 1,
  parameter int unsigned CNT_WIDTH  = 3,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  ready,
  output logic                  valid,
  output logic [CNT_WIDTH-1:0]  row_idx,
  output logic [CNT_WIDTH-1:0]  col_idx,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  cnt_clr,
  output logic                  col_cnt_en,
  output logic                  row_cnt_en,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned CW1 = CNT_WIDTH + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CLEAR = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // Limits compared one bit wider than the indices so index + STRIDE cannot wrap.
  localparam logic [CW1-1:0]       STEP_W  = CW1'(STRIDE);
  localparam logic [CW1-1:0]       COLS_W  = CW1'(COLS);
  localparam logic [CW1-1:0]       ROWS_W  = CW1'(ROWS);
  localparam logic [CNT_WIDTH-1:0] STEP    = CNT_WIDTH'(STRIDE);

  logic [1:0]           state;
  logic [1:0]           state_next;
  logic [CNT_WIDTH-1:0] row_next;
  logic [CNT_WIDTH-1:0] col_next;
  logic                 last_col;
  logic                 last_row;
  logic                 accept;

  // State and index registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      row_idx <= '0;
      col_idx <= '0;
    end else begin
      state   <= state_next;
      row_idx <= row_next;
      col_idx <= col_next;
    end
  end

  // Next-state, index update and output decode.
  always_comb begin
    state_next = state;
    row_next   = row_idx;
    col_next   = col_idx;
    valid      = 1'b0;
    busy       = 1'b0;
    cnt_clr    = 1'b0;
    done       = 1'b0;
    col_cnt_en = 1'b0;
    row_cnt_en = 1'b0;
    accept     = 1'b0;
    last_col   = ({1'b0, col_idx} + STEP_W) >= COLS_W;
    last_row   = ({1'b0, row_idx} + STEP_W) >= ROWS_W;

    case (state)
      IDLE: begin
        if (start && !abort) state_next = CLEAR;
      end
      CLEAR: begin
        cnt_clr    = 1'b1;
        busy       = 1'b1;
        row_next   = '0;
        col_next   = '0;
        state_next = RUN;
      end
      RUN: begin
        busy   = 1'b1;
        valid  = 1'b1;
        accept = ready && !abort;
        if (accept) begin
          if (!last_col) begin
            col_next   = col_idx + STEP;
            col_cnt_en = 1'b1;
          end else if (!last_row) begin
            col_next   = '0;
            row_next   = row_idx + STEP;
            col_cnt_en = 1'b1;
            row_cnt_en = 1'b1;
          end else begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        done       = 1'b1;
        row_next   = '0;
        col_next   = '0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Abort beats any accept in the same cycle.
    if (abort && state != IDLE) begin
      state_next = IDLE;
      row_next   = '0;
      col_next   = '0;
    end
  end

  assign addr = ADDR_WIDTH'(32'(row_idx) * COLS + 32'(col_idx));

endmodule

// File: tb/tb_scan_sequencer.sv
// Scoreboard bench for scan_sequencer: three parameterisations driven one at a time,
// expected beats generated from nested row/column loops.
module tb_scan_sequencer;

  typedef struct packed {
    logic       is_done;
    logic [2:0] r;
    logic [2:0] c;
    logic [3:0] a;
    logic       re;
    logic       ce;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       abort;
  logic       ready;
  logic       start      [3];
  logic       valid      [3];
  logic [2:0] row_idx    [3];
  logic [2:0] col_idx    [3];
  logic [3:0] addr       [3];
  logic       cnt_clr    [3];
  logic       col_cnt_en [3];
  logic       row_cnt_en [3];
  logic       busy       [3];
  logic       done       [3];

  exp_t q[$];
  int   cur = 0;
  int   n_total = 0;
  int   n_pass = 0;
  int   acc_cnt = 0;
  int   done_cnt = 0;
  int   busy_cycles = 0;
  logic       held = 1'b0;
  logic [2:0] hr, hc;
  logic [3:0] ha;

  always #5 clk = ~clk;

  scan_sequencer #(.ROWS(3), .COLS(4), .STRIDE(1), .CNT_WIDTH(3), .ADDR_WIDTH(4)) u_dut0 (
    .clk(clk), .reset(reset), .start(start[0]), .abort(abort), .ready(ready),
    .valid(valid[0]), .row_idx(row_idx[0]), .col_idx(col_idx[0]), .addr(addr[0]),
    .cnt_clr(cnt_clr[0]), .col_cnt_en(col_cnt_en[0]), .row_cnt_en(row_cnt_en[0]),
    .busy(busy[0]), .done(done[0]));

  scan_sequencer #(.ROWS(3), .COLS(4), .STRIDE(2), .CNT_WIDTH(3), .ADDR_WIDTH(4)) u_dut1 (
    .clk(clk), .reset(reset), .start(start[1]), .abort(abort), .ready(ready),
    .valid(valid[1]), .row_idx(row_idx[1]), .col_idx(col_idx[1]), .addr(addr[1]),
    .cnt_clr(cnt_clr[1]), .col_cnt_en(col_cnt_en[1]), .row_cnt_en(row_cnt_en[1]),
    .busy(busy[1]), .done(done[1]));

  scan_sequencer #(.ROWS(1), .COLS(1), .STRIDE(1), .CNT_WIDTH(3), .ADDR_WIDTH(4)) u_dut2 (
    .clk(clk), .reset(reset), .start(start[2]), .abort(abort), .ready(ready),
    .valid(valid[2]), .row_idx(row_idx[2]), .col_idx(col_idx[2]), .addr(addr[2]),
    .cnt_clr(cnt_clr[2]), .col_cnt_en(col_cnt_en[2]), .row_cnt_en(row_cnt_en[2]),
    .busy(busy[2]), .done(done[2]));

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t inst=%0d)", name, act, exp, $time, cur);
  endtask

  function automatic int rows_of(input int inst);
    return (inst == 2) ? 1 : 3;
  endfunction
  function automatic int cols_of(input int inst);
    return (inst == 2) ? 1 : 4;
  endfunction
  function automatic int stride_of(input int inst);
    return (inst == 1) ? 2 : 1;
  endfunction

  // Reference: visit every strided (row, col) in row-major order, then one done token.
  task automatic push_scan(input int inst);
    int   rows = rows_of(inst);
    int   cols = cols_of(inst);
    int   s    = stride_of(inst);
    exp_t e;
    for (int r = 0; r < rows; r += s) begin
      for (int c = 0; c < cols; c += s) begin
        e.is_done = 1'b0;
        e.r  = 3'(r);
        e.c  = 3'(c);
        e.a  = 4'(r * cols + c);
        e.re = (c + s >= cols) && (r + s < rows);
        e.ce = !((c + s >= cols) && (r + s >= rows));
        q.push_back(e);
      end
    end
    e = '0;
    e.is_done = 1'b1;
    q.push_back(e);
  endtask

  function automatic logic rdy(input int mode, input int k);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (k % 3) == 0;
    return 1'($urandom % 2);
  endfunction

  // Monitor: pops the scoreboard on each accepted beat and each done pulse.
  always @(negedge clk) begin
    if (reset) begin
      held = 1'b0;
    end else begin
      if (busy[cur]) busy_cycles++;
      if (held && valid[cur]) begin
        chk("hold_row", row_idx[cur], hr);
        chk("hold_col", col_idx[cur], hc);
        chk("hold_addr", addr[cur], ha);
      end
      if (valid[cur] && ready && !abort) begin
        chk("beat_expected", int'(q.size() > 0 && !q[0].is_done), 1);
        if (q.size() > 0 && !q[0].is_done) begin
          exp_t e;
          e = q.pop_front();
          chk("row_idx", row_idx[cur], e.r);
          chk("col_idx", col_idx[cur], e.c);
          chk("addr", addr[cur], e.a);
          chk("col_cnt_en", col_cnt_en[cur], e.ce);
          chk("row_cnt_en", row_cnt_en[cur], e.re);
          acc_cnt++;
        end
      end else begin
        chk("col_cnt_en_noaccept", col_cnt_en[cur], 0);
        chk("row_cnt_en_noaccept", row_cnt_en[cur], 0);
      end
      if (done[cur]) begin
        chk("done_expected", int'(q.size() > 0 && q[0].is_done), 1);
        if (q.size() > 0 && q[0].is_done) void'(q.pop_front());
        chk("done_valid_low", valid[cur], 0);
        done_cnt++;
      end
      held = valid[cur] && !ready && !abort;
      hr = row_idx[cur];
      hc = col_idx[cur];
      ha = addr[cur];
    end
  end

  // Starts a scan; returns at CLEAR+1 with the first beat presented.
  task automatic begin_scan(input int inst);
    cur = inst;
    chk("sb_empty_before", q.size(), 0);
    q.delete();
    push_scan(inst);
    acc_cnt = 0;
    busy_cycles = 0;
    start[inst] = 1'b1;
    @(posedge clk); #1;
    start[inst] = 1'b0;
    chk("cnt_clr", cnt_clr[inst], 1);
    chk("busy_clear", busy[inst], 1);
    chk("valid_clear", valid[inst], 0);
    @(posedge clk); #1;
    chk("first_valid", valid[inst], 1);
  endtask

  task automatic run_scan(input int inst, input int mode, input bit poke);
    int d0 = done_cnt;
    int s  = stride_of(inst);
    int nb = ((rows_of(inst) + s - 1) / s) * ((cols_of(inst) + s - 1) / s);
    begin_scan(inst);
    for (int k = 0; k < 600; k++) begin
      ready = rdy(mode, k);
      start[inst] = poke && (k == 2 || k == 5);
      @(posedge clk); #1;
      if (done_cnt != d0) break;
    end
    start[inst] = 1'b0;
    ready = 1'b0;
    chk("done_count", done_cnt - d0, 1);
    chk("beat_count", acc_cnt, nb);
    chk("sb_empty_after", q.size(), 0);
    if (mode == 0) chk("busy_cycles", busy_cycles, nb + 1);
    chk("busy_after", busy[inst], 0);
    chk("valid_after", valid[inst], 0);
    chk("done_after", done[inst], 0);
  endtask

  task automatic run_until(input int beats);
    for (int k = 0; k < 100 && acc_cnt < beats; k++) begin
      ready = 1'b1;
      @(posedge clk); #1;
    end
    chk("reached_beat", acc_cnt, beats);
  endtask

  task automatic run_abort(input int inst);
    int d0 = done_cnt;
    begin_scan(inst);
    run_until(5);
    abort = 1'b1;
    ready = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    ready = 1'b0;
    q.delete();
    chk("abort_valid", valid[inst], 0);
    chk("abort_busy", busy[inst], 0);
    chk("abort_done", done[inst], 0);
    chk("abort_row", row_idx[inst], 0);
    chk("abort_col", col_idx[inst], 0);
    repeat (4) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_accepted", acc_cnt, 5);
  endtask

  task automatic run_reset(input int inst);
    begin_scan(inst);
    run_until(6);
    #2 reset = 1'b1;
    #1;
    q.delete();
    chk("rst_valid", valid[inst], 0);
    chk("rst_busy", busy[inst], 0);
    chk("rst_row", row_idx[inst], 0);
    chk("rst_col", col_idx[inst], 0);
    chk("rst_addr", addr[inst], 0);
    chk("rst_done", done[inst], 0);
    ready = 1'b0;
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_stays_idle", busy[inst], 0);
  endtask

  initial begin
    reset = 1'b1;
    abort = 1'b0;
    ready = 1'b0;
    for (int i = 0; i < 3; i++) start[i] = 1'b0;
    #2;
    for (int i = 0; i < 3; i++) begin
      chk("reset_valid", valid[i], 0);
      chk("reset_busy", busy[i], 0);
      chk("reset_done", done[i], 0);
      chk("reset_cnt_clr", cnt_clr[i], 0);
      chk("reset_row", row_idx[i], 0);
      chk("reset_col", col_idx[i], 0);
      chk("reset_addr", addr[i], 0);
    end
    #20 reset = 1'b0;
    @(posedge clk); #1;

    run_scan(0, 0, 1'b0);
    run_scan(1, 0, 1'b0);
    run_scan(2, 0, 1'b0);
    run_scan(0, 1, 1'b0);
    run_scan(0, 0, 1'b1);
    run_abort(0);

    cur = 0;
    start[0] = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", busy[0], 0);
    chk("start_abort_clr", cnt_clr[0], 0);

    run_reset(0);
    run_scan(0, 0, 1'b0);

    for (int n = 0; n < 8; n++) begin
      int inst = int'($urandom % 3);
      run_scan(inst, 2, 1'($urandom % 2));
    end

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
